// File: rtl/scope_ui_pkg.sv
// Shared scope front-panel UI definitions: repeat FSM encoding and default
// time-base constants for a 50 MHz core clock.
package scope_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam int TICK_DIV_1MS     = 50000;
    localparam int HOLD_TICKS_DEF   = 500;
    localparam int REPEAT_TICKS_DEF = 100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Latency: tick is decoded combinationally from the counter; no backpressure.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/button_event_ctrl.sv
// Serialises debounced button presses and auto-repeats into one event stream.
// Latency: press seen at edge k is presented after edge k+1; holds event while !evt_ready.
module button_event_ctrl
    import scope_ui_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = TICK_DIV_1MS,
    parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_BTN-1:0]         btn,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_repeat,
    output logic [N_BTN-1:0]         held
);

    localparam int             IW     = $clog2(N_BTN);
    localparam int             NTW    = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);
    localparam logic [NTW-1:0] HOLD_C = NTW'(HOLD_TICKS);
    localparam logic [NTW-1:0] REP_C  = NTW'(REPEAT_TICKS);

    logic [N_BTN-1:0] r_held;
    logic [N_BTN-1:0] r_pending;
    logic             r_rep_pending;
    rep_state_t       r_state;
    logic [IW-1:0]    r_cur;
    logic [NTW-1:0]   r_ntick;
    logic             r_evt_valid;
    logic [IW-1:0]    r_evt_id;
    logic             r_evt_repeat;

    logic             w_tick;
    logic [N_BTN-1:0] w_rise;
    logic [IW-1:0]    w_pend_idx;
    logic [IW-1:0]    w_low_idx;
    logic             w_any_pend;
    logic             w_any_held;
    logic             w_load;
    logic             w_take_press;
    logic             w_take_rep;
    logic [N_BTN-1:0] w_pend_clr;
    logic [NTW-1:0]   w_ntick_inc;
    logic [NTW-1:0]   w_thresh;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    // Lowest index wins both for press delivery and for repeat tracking.
    always_comb begin
        w_pend_idx = '0;
        w_low_idx  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (r_pending[i]) w_pend_idx = IW'(i);
            if (r_held[i])    w_low_idx  = IW'(i);
        end
    end

    assign w_rise       = btn & ~r_held;
    assign w_any_pend   = |r_pending;
    assign w_any_held   = |r_held;
    assign w_load       = !r_evt_valid || evt_ready;
    assign w_take_press = w_load && w_any_pend;
    assign w_take_rep   = w_load && !w_any_pend && r_rep_pending;
    assign w_pend_clr   = w_take_press ? (N_BTN'(1) << w_pend_idx) : '0;
    assign w_ntick_inc  = r_ntick + 1'b1;
    assign w_thresh     = (r_state == ST_HOLD) ? HOLD_C : REP_C;

    // Reset to all-ones so buttons already down at reset release are not presses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_held    <= '1;
            r_pending <= '0;
        end else begin
            r_held    <= btn;
            r_pending <= (r_pending & ~w_pend_clr) | w_rise;
        end
    end

    // Later assignments override the consume-clear, so a new period set wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cur         <= '0;
            r_ntick       <= '0;
            r_rep_pending <= 1'b0;
        end else begin
            if (w_take_rep) r_rep_pending <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_held) begin
                        r_cur   <= w_low_idx;
                        r_ntick <= '0;
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    if (!r_held[r_cur]) begin
                        r_state       <= ST_IDLE;
                        r_rep_pending <= 1'b0;
                    end else if (w_low_idx < r_cur) begin
                        r_cur         <= w_low_idx;
                        r_ntick       <= '0;
                        r_rep_pending <= 1'b0;
                        r_state       <= ST_HOLD;
                    end else if (w_tick) begin
                        if (w_ntick_inc == w_thresh) begin
                            r_rep_pending <= 1'b1;
                            r_ntick       <= '0;
                            r_state       <= ST_REPEAT;
                        end else begin
                            r_ntick <= w_ntick_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_evt_repeat <= 1'b0;
        end else if (w_load) begin
            if (w_take_press) begin
                r_evt_valid  <= 1'b1;
                r_evt_id     <= w_pend_idx;
                r_evt_repeat <= 1'b0;
            end else if (w_take_rep) begin
                r_evt_valid  <= 1'b1;
                r_evt_id     <= r_cur;
                r_evt_repeat <= 1'b1;
            end else begin
                r_evt_valid  <= 1'b0;
            end
        end
    end

    assign evt_valid  = r_evt_valid;
    assign evt_id     = r_evt_id;
    assign evt_repeat = r_evt_repeat;
    assign held       = r_held;

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Sits between the per-button debounce instances and the scope settings logic (timebase, volts/div, trigger level).
- Turns N debounced button levels into one serialized stream of events: a press event on each rising edge, plus auto-repeat events while a button stays held.
- Arbitrates simultaneous presses by fixed priority and delivers events over a valid/ready handshake.

Parameters:
- N_BTN, 4, number of debounced button inputs (2..8).
- TICK_DIV, 50000, clock cycles per time-base tick (1 ms at 50 MHz).
- HOLD_TICKS, 500, ticks a button must be held before the first repeat event.
- REPEAT_TICKS, 100, ticks between subsequent repeat events.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn  in  N_BTN  debounced button levels, 1 = pressed; synchronous to clock.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a clock edge.
- evt_id  out  clog2(N_BTN)  index of the button for the event.
- evt_repeat  out  1  0 = initial press, 1 = auto-repeat.
- held  out  N_BTN  registered copy of btn.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - evt_valid=0, evt_id=0, evt_repeat=0.
  - held=all ones, so buttons already down when reset releases generate no press event.
  - pending=0, rep_pending=0, tick counter=0, FSM=IDLE.
- Tick generator: free-running counter 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1, then count wraps to 0.
- Edge detection:
  - rise = btn & ~held, evaluated combinationally on registered held.
  - held <= btn every cycle.
  - Each rise bit sets a sticky pending[i].
- Repeat FSM. It tracks the lowest-index held button, cur; ntick is the tick count inside a state.
  - IDLE: when any held bit is 1, latch cur, clear ntick, go to HOLD.
  - HOLD: ntick increments on tick. At ntick==HOLD_TICKS, set rep_pending, clear ntick, go to REPEAT.
  - REPEAT: ntick increments on tick. At ntick==REPEAT_TICKS, set rep_pending and clear ntick.
  - HOLD or REPEAT: if held[cur]==0, go to IDLE and clear rep_pending. If a lower index becomes held, re-latch cur, clear ntick and rep_pending, and go to HOLD.
  - First repeat arrives (HOLD_TICKS-1)*TICK_DIV+1 .. HOLD_TICKS*TICK_DIV cycles after entering HOLD (tick-phase jitter).
- rep_pending saturates: extra periods elapsing while it is already set are dropped, not counted.
- Output register: loads when evt_valid==0, or when evt_valid && evt_ready in the same cycle.
  - Load priority 1: lowest-index set pending bit. evt_id=i, evt_repeat=0, clear pending[i].
  - Load priority 2: else, if rep_pending: evt_id=cur, evt_repeat=1, clear rep_pending.
  - Otherwise evt_valid <= 0.
  - evt_id and evt_repeat hold stable while evt_valid && !evt_ready.
- Latency: btn rising at edge k sets pending at edge k. With an idle output, evt_valid=1 after edge k+1. Back-to-back events sustain one per cycle when evt_ready=1.
- Simultaneous events:
  - Set and clear of the same pending bit in one cycle: set wins.
  - Several rises in one cycle: all latch; they are delivered in index order.
  - Press events always win over a waiting repeat.
- Width rules:
  - ntick width is clog2(max(HOLD_TICKS, REPEAT_TICKS)+1).
  - Compare constants are extended to ntick width.
  - No wrap is possible because the counter clears at the threshold.
- Reset mid-operation: an event that is valid but not yet accepted is discarded. Nothing is replayed after reset.

Decomposition:
- Shared package scope_ui_pkg:
  - FSM state encoding: IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2.
  - Default timing constants TICK_DIV_1MS, HOLD_TICKS_DEF, REPEAT_TICKS_DEF.
- One sub-module, tick_gen: parameter TICK_DIV, ports clock/reset_n/tick. Reusable for other UI timing.
- The debounce instances stay outside this block.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2, N_BTN=4):
- Reset with btn=4'b0010 held, then release reset -> no event; held=4'b0010. Release and re-press btn[1] -> one event, id=1, repeat=0.
- btn=0->4'b0100 at edge k, evt_ready=1 -> evt_valid=1 after edge k+1, id=2, repeat=0, accepted in one cycle. Release within 8 cycles -> no repeat.
- Hold btn[0] with evt_ready=1:
  - press event at k+1;
  - first repeat (id=0, repeat=1) between 9 and 12 cycles after HOLD entry;
  - further repeats every 8 cycles;
  - release -> stops, no trailing event.
- btn 0->4'b1011 in one cycle, evt_ready=0 for 5 cycles then 1 -> id=0 held stable for 5 cycles, then ids 0,1,3 on consecutive cycles.
- Hold btn[2] into REPEAT, keep evt_ready=0 for 30 cycles -> exactly one repeat is queued (saturation), delivered on ready.
- Hold btn[2] into REPEAT, then press btn[1] -> press event id=1; FSM re-enters HOLD for cur=1; next repeat has id=1.
- Assert reset_n=0 for 1 cycle while evt_valid=1 -> evt_valid=0 immediately (asynchronous), pending cleared.
